// File: rtl/addr_trans_pkg.sv
// addr_trans_pkg: satp mode encodings, satp field layout per XLEN and flush FSM types.
package addr_trans_pkg;
    typedef enum logic [2:0] {BARE, SV32, SV39, SV48, SV57, SV64} satp_mode_t;
    typedef enum logic [1:0] {IDLE, FLUSH, DONE} flush_state_t;
    typedef struct packed {
        logic       valid;
        satp_mode_t mode;
    } mode_dec_t;

    localparam int RV32_MODE_BIT = 31;
    localparam int RV32_ASID_LSB = 22;
    localparam int RV32_ASID_W   = 9;
    localparam int RV32_PPN_W    = 22;
    localparam int RV64_MODE_LSB = 60;
    localparam int RV64_ASID_LSB = 44;
    localparam int RV64_ASID_W   = 16;
    localparam int RV64_PPN_W    = 44;

    localparam logic [3:0] RV64_BARE = 4'd0;
    localparam logic [3:0] RV64_SV39 = 4'd8;
    localparam logic [3:0] RV64_SV48 = 4'd9;
    localparam logic [3:0] RV64_SV57 = 4'd10;
    localparam logic [3:0] RV64_SV64 = 4'd11;

    function automatic mode_dec_t satp_decode(input logic [63:0] s, input int xlen);
        mode_dec_t d;
        d.valid = 1'b1;
        d.mode  = BARE;
        if (xlen == 32)
            d.mode = s[RV32_MODE_BIT] ? SV32 : BARE;
        else
            case (s[RV64_MODE_LSB +: 4])
                RV64_BARE: d.mode = BARE;
                RV64_SV39: d.mode = SV39;
                RV64_SV48: d.mode = SV48;
                RV64_SV57: d.mode = SV57;
                RV64_SV64: d.mode = SV64;
                default:   d.valid = 1'b0;
            endcase
        return d;
    endfunction

    function automatic logic [15:0] satp_asid(input logic [63:0] s, input int xlen);
        return xlen == 32 ? 16'(s[RV32_ASID_LSB +: RV32_ASID_W]) : s[RV64_ASID_LSB +: RV64_ASID_W];
    endfunction

    function automatic logic [43:0] satp_ppn(input logic [63:0] s, input int xlen);
        return xlen == 32 ? 44'(s[0 +: RV32_PPN_W]) : s[0 +: RV64_PPN_W];
    endfunction

    // bit order {sv64,sv57,sv48,sv39,sv32}, matching MODE_MASK
    function automatic logic [4:0] mode_onehot(input satp_mode_t m);
        return m == BARE ? 5'd0 : 5'(1 << (int'(m) - 1));
    endfunction
endpackage

// File: rtl/addr_trans_ctrl_flush_tracker.sv
// flush_tracker: per-client outstanding flush mask; all_done looks ahead to this cycle's acks.
module flush_tracker
    import addr_trans_pkg::*;
#(
    parameter int NUM_CLIENTS = 3
) (
    input  logic                   CLK,
    input  logic                   nRST,
    input  logic                   start,
    input  logic [NUM_CLIENTS-1:0] flush_ack,
    output logic [NUM_CLIENTS-1:0] flush_req,
    output logic                   all_done
);
    always_ff @(posedge CLK) begin
        if (!nRST)
            flush_req <= '0;
        else
            flush_req <= start ? '1 : flush_req & ~flush_ack;
    end

    assign all_done = (flush_req & ~flush_ack) == '0;
endmodule

// File: rtl/addr_trans_ctrl.sv
// addr_trans_ctrl: owns satp, decodes translation mode/enables and sequences TLB/walker flushes
// on SFENCE.VMA or satp MODE/ASID change.
module addr_trans_ctrl
    import addr_trans_pkg::*;
#(
    parameter int         XLEN        = 32,
    parameter int         NUM_CLIENTS = 3,
    parameter logic [4:0] MODE_MASK   = 5'b00001
) (
    input  logic                   CLK,
    input  logic                   nRST,
    input  logic                   satp_wen,
    input  logic [XLEN-1:0]        satp_wdata,
    output logic [XLEN-1:0]        satp_rdata,
    input  logic [1:0]             priv_level,
    input  logic                   mstatus_mprv,
    input  logic [1:0]             mstatus_mpp,
    input  logic                   sfence_req,
    output logic                   sfence_ack,
    output logic [NUM_CLIENTS-1:0] flush_req,
    input  logic [NUM_CLIENTS-1:0] flush_ack,
    output logic                   busy,
    output logic                   sv32,
    output logic                   sv39,
    output logic                   sv48,
    output logic                   sv57,
    output logic                   sv64,
    output logic                   addr_trans_on_i,
    output logic                   addr_trans_on_d,
    output logic [15:0]            asid,
    output logic [43:0]            root_ppn
);
    flush_state_t    state, state_nxt;
    logic [XLEN-1:0] satp;
    logic [63:0]     w64, s64;
    mode_dec_t       wdec, cur;
    logic [4:0]      mode_oh;
    logic [1:0]      eff_priv;
    logic            wr_ok, satp_trig, start, all_done, reflush, sfence_seen;

    assign w64        = 64'(satp_wdata);
    assign s64        = 64'(satp);
    assign wdec       = satp_decode(w64, XLEN);
    assign cur        = satp_decode(s64, XLEN);
    assign eff_priv   = mstatus_mprv ? mstatus_mpp : priv_level;
    // WARL: unknown or unsupported modes leave satp untouched
    assign wr_ok      = satp_wen && wdec.valid && (wdec.mode == BARE || |(mode_onehot(wdec.mode) & MODE_MASK));
    assign satp_trig  = wr_ok && (wdec.mode != cur.mode || satp_asid(w64, XLEN) != satp_asid(s64, XLEN));
    assign satp_rdata = satp;
    assign busy       = state != IDLE || start;
    assign sfence_ack = state == DONE && sfence_seen;
    assign {sv64, sv57, sv48, sv39, sv32} = mode_oh;

    always_comb begin
        start     = (state == IDLE && (sfence_req || satp_trig)) || (state == DONE && (reflush || satp_trig));
        state_nxt = start ? FLUSH : state == FLUSH ? (all_done ? DONE : FLUSH) : IDLE;
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state           <= IDLE;
            satp            <= '0;
            reflush         <= 1'b0;
            sfence_seen     <= 1'b0;
            mode_oh         <= '0;
            asid            <= '0;
            root_ppn        <= '0;
            addr_trans_on_i <= 1'b0;
            addr_trans_on_d <= 1'b0;
        end else begin
            state           <= state_nxt;
            if (wr_ok)
                satp <= satp_wdata;
            reflush         <= state == FLUSH && (reflush || satp_trig);
            sfence_seen     <= state == DONE ? 1'b0 : sfence_req || (state == FLUSH && sfence_seen);
            mode_oh         <= mode_onehot(cur.mode);
            asid            <= satp_asid(s64, XLEN);
            root_ppn        <= satp_ppn(s64, XLEN);
            addr_trans_on_i <= cur.mode != BARE && priv_level != 2'd3;
            addr_trans_on_d <= cur.mode != BARE && eff_priv != 2'd3;
        end
    end

    flush_tracker #(.NUM_CLIENTS(NUM_CLIENTS)) u_tracker (
        .CLK      (CLK),
        .nRST     (nRST),
        .start    (start),
        .flush_ack(flush_ack),
        .flush_req(flush_req),
        .all_done (all_done)
    );

    sfence_hold: assert property (@(posedge CLK) disable iff (!nRST) $fell(sfence_req) |-> $past(sfence_ack))
        else $error("sfence_req dropped before sfence_ack");
endmodule
